pipe_cla_adder: RTL and testbench
=================================

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/sum width in bits; SHALL be a multiple of 4, minimum 4.
REQ-002 Parameter LAT, default 2: pipeline latency in cycles; only values 1 and 2 SHALL be legal.
REQ-003 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operand beat present.
REQ-006 Port in_ready  output  1  block accepts the beat this cycle.
REQ-007 Port A  input  WIDTH  operand A.
REQ-008 Port B  input  WIDTH  operand B.
REQ-009 Port Ci  input  1  carry-in, used when Sub=0.
REQ-010 Port Sub  input  1  1 = compute A - B.
REQ-011 Port out_valid  output  1  result beat present.
REQ-012 Port out_ready  input  1  downstream accepts result.
REQ-013 Port S  output  WIDTH  sum/difference.
REQ-014 Port Co  output  1  carry out of bit WIDTH-1.
REQ-015 Port GG  output  1  word-level group generate.
REQ-016 Port PG  output  1  word-level group propagate.
REQ-017 Port Ovf  output  1  signed overflow; present only under CLA_OVF_EN.

Function
REQ-018 Adder SHALL be built from 4-bit carry-lookahead groups; group carries SHALL be produced by a second lookahead level, not by ripple between groups.
REQ-019 Effective operands: Sub=0 -> A + B + Ci; Sub=1 -> A + ~B + 1, Ci ignored.
REQ-020 {Co,S} SHALL equal the (WIDTH+1)-bit result of REQ-019; GG/PG SHALL be the word generate/propagate of A and effective B.
REQ-021 LAT=2: stage 1 SHALL register per-group G/P, partial sums and effective carry-in; stage 2 SHALL register S, Co, GG, PG (and Ovf).
REQ-022 LAT=1: only the output register SHALL exist.
REQ-023 A beat SHALL transfer in when in_valid and in_ready are both 1; out when out_valid and out_ready are both 1.
REQ-024 Each stage SHALL carry a valid bit; stage advances when it is empty or the next stage advances in the same cycle; in_ready SHALL equal stage-1 advance condition (combinational from out_ready).
REQ-025 Throughput SHALL be one beat per cycle with out_ready held 1; result appears LAT cycles after acceptance.
REQ-026 While out_valid=1 and out_ready=0, S, Co, GG, PG, Ovf SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-027 With pipeline full and out_ready=0, in_ready SHALL be 0; when out_ready returns 1, simultaneous output and input transfer SHALL occur in the same cycle.
REQ-028 Beats SHALL leave in acceptance order; in_valid=0 cycles SHALL create bubbles that are never presented as out_valid.

Reset
REQ-029 rst_n=0 SHALL immediately clear all valid bits and drive out_valid=0, S=0, Co=0, GG=0, PG=0, Ovf=0, independent of clk.
REQ-030 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after release.

Configuration
REQ-032 Macro CLA_OVF_EN defined: Ovf port exists, registered with the result, = carry into MSB XOR Co.
REQ-033 Macro CLA_OVF_EN undefined: Ovf port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 WIDTH=16, LAT=2: A=0xFFFF, B=0x0001, Ci=0, Sub=0 -> after 2 cycles S=0x0000, Co=1, PG=0, GG=1.
REQ-035 A=0x0005, B=0x0007, Sub=1, Ci=1 -> S=0xFFFE, Co=0; Ci ignored; Ovf=0 under CLA_OVF_EN.
REQ-036 A=0x7FFF, B=0x0001, Sub=0, CLA_OVF_EN -> S=0x8000, Ovf=1, Co=0.
REQ-037 Stream 8 beats back-to-back, out_ready=0 cycles 3-5 -> in_ready=0 once 2 beats held, all 8 results in order, stable during stall.
REQ-038 Assert rst_n=0 with 2 beats in flight -> out_valid=0 asynchronously, no results after release, in_ready=1 first cycle after.

Source files
------------

// File: rtl/pipe_cla_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_adder_if
// Description : Operand/result handshake bundle for pipe_cla_adder.
//               Ovf exists only when CLA_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_cla_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             GG;
    logic             PG;
`ifdef CLA_OVF_EN
    logic             Ovf;

    modport master (
        output in_valid, A, B, Ci, Sub, out_ready,
        input  in_ready, out_valid, S, Co, GG, PG, Ovf
    );
    modport slave (
        input  in_valid, A, B, Ci, Sub, out_ready,
        output in_ready, out_valid, S, Co, GG, PG, Ovf
    );
`else
    modport master (
        output in_valid, A, B, Ci, Sub, out_ready,
        input  in_ready, out_valid, S, Co, GG, PG
    );
    modport slave (
        input  in_valid, A, B, Ci, Sub, out_ready,
        output in_ready, out_valid, S, Co, GG, PG
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_cla_adder
// Description : Valid/ready pipelined two-level carry-lookahead adder/subtractor
//               (LAT = 1 or 2). Define CLA_OVF_EN to add the signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_cla_adder #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pipe_cla_adder_if.slave bus
);
    localparam int C_NGRP = WIDTH / 4;

    function automatic logic [1:0] cla4_gp(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] g;
        logic [3:0] p;
        g = a & b;
        p = a ^ b;
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
    endfunction

    function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                            input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return p ^ c;
    endfunction

    // ------------------------------------------------------------------------
    // Stage 1: effective operands, per-group G/P and carry-select partial sums
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]  w_beff;
    logic              w_cin_eff;
    logic [C_NGRP-1:0] w_grp_g;
    logic [C_NGRP-1:0] w_grp_p;
    logic [WIDTH-1:0]  w_grp_sum0;
    logic [WIDTH-1:0]  w_grp_sum1;

    always_comb begin
        w_beff     = bus.Sub ? ~bus.B : bus.B;
        w_cin_eff  = bus.Sub | bus.Ci;
        w_grp_g    = '0;
        w_grp_p    = '0;
        w_grp_sum0 = '0;
        w_grp_sum1 = '0;
        for (int k = 0; k < C_NGRP; k++) begin
            {w_grp_g[k], w_grp_p[k]} = cla4_gp(bus.A[4*k +: 4], w_beff[4*k +: 4]);
            w_grp_sum0[4*k +: 4]     = cla4_sum(bus.A[4*k +: 4], w_beff[4*k +: 4], 1'b0);
            w_grp_sum1[4*k +: 4]     = cla4_sum(bus.A[4*k +: 4], w_beff[4*k +: 4], 1'b1);
        end
    end

`ifdef CLA_OVF_EN
    // MSB half-sum lets stage 2 recover the carry into the MSB from the final sum bit.
    logic w_pmsb;
    assign w_pmsb = bus.A[WIDTH-1] ^ w_beff[WIDTH-1];
    logic w_s2_pmsb;
`endif

    // Operands seen by the second lookahead level
    logic              w_s2_vld;
    logic [C_NGRP-1:0] w_s2_g;
    logic [C_NGRP-1:0] w_s2_p;
    logic [WIDTH-1:0]  w_s2_sum0;
    logic [WIDTH-1:0]  w_s2_sum1;
    logic              w_s2_cin;

    logic r_out_vld_q;
    logic w_out_adv;
    assign w_out_adv = ~r_out_vld_q | bus.out_ready;

    if (LAT == 1) begin : g_lat1
        assign bus.in_ready = w_out_adv & rst_n;
        assign w_s2_vld     = bus.in_valid;
        assign w_s2_g       = w_grp_g;
        assign w_s2_p       = w_grp_p;
        assign w_s2_sum0    = w_grp_sum0;
        assign w_s2_sum1    = w_grp_sum1;
        assign w_s2_cin     = w_cin_eff;
`ifdef CLA_OVF_EN
        assign w_s2_pmsb    = w_pmsb;
`endif
    end else begin : g_lat2
        logic              r_s1_vld_q,  w_s1_vld_d;
        logic [C_NGRP-1:0] r_s1_g_q,    w_s1_g_d;
        logic [C_NGRP-1:0] r_s1_p_q,    w_s1_p_d;
        logic [WIDTH-1:0]  r_s1_sum0_q, w_s1_sum0_d;
        logic [WIDTH-1:0]  r_s1_sum1_q, w_s1_sum1_d;
        logic              r_s1_cin_q,  w_s1_cin_d;
        logic              w_s1_adv;
`ifdef CLA_OVF_EN
        logic              r_s1_pmsb_q, w_s1_pmsb_d;
`endif

        assign w_s1_adv     = ~r_s1_vld_q | w_out_adv;
        assign bus.in_ready = w_s1_adv & rst_n;

        always_comb begin
            w_s1_vld_d  = r_s1_vld_q;
            w_s1_g_d    = r_s1_g_q;
            w_s1_p_d    = r_s1_p_q;
            w_s1_sum0_d = r_s1_sum0_q;
            w_s1_sum1_d = r_s1_sum1_q;
            w_s1_cin_d  = r_s1_cin_q;
`ifdef CLA_OVF_EN
            w_s1_pmsb_d = r_s1_pmsb_q;
`endif
            if (w_s1_adv) begin
                w_s1_vld_d = bus.in_valid;
                if (bus.in_valid) begin
                    w_s1_g_d    = w_grp_g;
                    w_s1_p_d    = w_grp_p;
                    w_s1_sum0_d = w_grp_sum0;
                    w_s1_sum1_d = w_grp_sum1;
                    w_s1_cin_d  = w_cin_eff;
`ifdef CLA_OVF_EN
                    w_s1_pmsb_d = w_pmsb;
`endif
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_vld_q  <= 1'b0;
                r_s1_g_q    <= '0;
                r_s1_p_q    <= '0;
                r_s1_sum0_q <= '0;
                r_s1_sum1_q <= '0;
                r_s1_cin_q  <= 1'b0;
`ifdef CLA_OVF_EN
                r_s1_pmsb_q <= 1'b0;
`endif
            end else begin
                r_s1_vld_q  <= w_s1_vld_d;
                r_s1_g_q    <= w_s1_g_d;
                r_s1_p_q    <= w_s1_p_d;
                r_s1_sum0_q <= w_s1_sum0_d;
                r_s1_sum1_q <= w_s1_sum1_d;
                r_s1_cin_q  <= w_s1_cin_d;
`ifdef CLA_OVF_EN
                r_s1_pmsb_q <= w_s1_pmsb_d;
`endif
            end
        end

        assign w_s2_vld  = r_s1_vld_q;
        assign w_s2_g    = r_s1_g_q;
        assign w_s2_p    = r_s1_p_q;
        assign w_s2_sum0 = r_s1_sum0_q;
        assign w_s2_sum1 = r_s1_sum1_q;
        assign w_s2_cin  = r_s1_cin_q;
`ifdef CLA_OVF_EN
        assign w_s2_pmsb = r_s1_pmsb_q;
`endif
    end

    // ------------------------------------------------------------------------
    // Stage 2: second lookahead level; every group carry is a flat sum of
    // products over group G/P, so no carry ripples from group to group.
    // ------------------------------------------------------------------------
    logic [C_NGRP:0]  w_gen;
    logic [C_NGRP:0]  w_pre;
    logic [C_NGRP:0]  w_gc;
    logic [WIDTH-1:0] w_sum;

    always_comb begin
        logic w_term;
        w_gen  = '0;
        w_pre  = '0;
        w_gc   = '0;
        w_sum  = '0;
        w_term = 1'b0;
        for (int k = 0; k <= C_NGRP; k++) begin
            w_pre[k] = 1'b1;
            for (int m = 0; m < k; m++) begin
                w_pre[k] = w_pre[k] & w_s2_p[m];
            end
            for (int j = 0; j < k; j++) begin
                w_term = w_s2_g[j];
                for (int m = j + 1; m < k; m++) begin
                    w_term = w_term & w_s2_p[m];
                end
                w_gen[k] = w_gen[k] | w_term;
            end
            w_gc[k] = w_gen[k] | (w_pre[k] & w_s2_cin);
        end
        for (int k = 0; k < C_NGRP; k++) begin
            w_sum[4*k +: 4] = w_gc[k] ? w_s2_sum1[4*k +: 4] : w_s2_sum0[4*k +: 4];
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    logic             w_out_vld_d;
    logic [WIDTH-1:0] r_s_q,  w_s_d;
    logic             r_co_q, w_co_d;
    logic             r_gg_q, w_gg_d;
    logic             r_pg_q, w_pg_d;
`ifdef CLA_OVF_EN
    logic             r_ovf_q, w_ovf_d;
`endif

    always_comb begin
        w_out_vld_d = r_out_vld_q;
        w_s_d       = r_s_q;
        w_co_d      = r_co_q;
        w_gg_d      = r_gg_q;
        w_pg_d      = r_pg_q;
`ifdef CLA_OVF_EN
        w_ovf_d     = r_ovf_q;
`endif
        if (w_out_adv) begin
            w_out_vld_d = w_s2_vld;
            if (w_s2_vld) begin
                w_s_d  = w_sum;
                w_co_d = w_gc[C_NGRP];
                w_gg_d = w_gen[C_NGRP];
                w_pg_d = w_pre[C_NGRP];
`ifdef CLA_OVF_EN
                w_ovf_d = (w_s2_pmsb ^ w_sum[WIDTH-1]) ^ w_gc[C_NGRP];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld_q <= 1'b0;
            r_s_q       <= '0;
            r_co_q      <= 1'b0;
            r_gg_q      <= 1'b0;
            r_pg_q      <= 1'b0;
`ifdef CLA_OVF_EN
            r_ovf_q     <= 1'b0;
`endif
        end else begin
            r_out_vld_q <= w_out_vld_d;
            r_s_q       <= w_s_d;
            r_co_q      <= w_co_d;
            r_gg_q      <= w_gg_d;
            r_pg_q      <= w_pg_d;
`ifdef CLA_OVF_EN
            r_ovf_q     <= w_ovf_d;
`endif
        end
    end

    assign bus.out_valid = r_out_vld_q;
    assign bus.S         = r_s_q;
    assign bus.Co        = r_co_q;
    assign bus.GG        = r_gg_q;
    assign bus.PG        = r_pg_q;
`ifdef CLA_OVF_EN
    assign bus.Ovf       = r_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_cla_adder
// Description : Self-checking bench for pipe_cla_adder (WIDTH=16, LAT=2) against
//               an arithmetic reference model; Ovf checked when CLA_OVF_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_cla_adder;
    localparam int W   = 16;
    localparam int LAT = 2;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         gg;
        logic         pg;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    bit   lat_strict = 1'b0;
    exp_t exp_q[$];

    bit           held_vld = 1'b0;
    logic [W-1:0] held_s;
    logic         held_co, held_gg, held_pg;
`ifdef CLA_OVF_EN
    logic         held_ovf;
`endif

    pipe_cla_adder_if #(.WIDTH(W)) bus ();

    pipe_cla_adder #(.WIDTH(W), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic on the effective operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sub, input int acc);
        exp_t       e;
        logic [W-1:0] be;
        logic [W:0]   r;
        logic [W:0]   r0;
        be    = sub ? ~b : b;
        r     = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
        r0    = {1'b0, a} + {1'b0, be};
        e.s   = r[W-1:0];
        e.co  = r[W];
        e.gg  = r0[W];
        e.pg  = ((a ^ be) == {W{1'b1}});
        e.ovf = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        e.acc = acc;
        return e;
    endfunction

    task automatic tick(output bit accepted);
        exp_t e;
        @(negedge clk);
        cyc++;
        check("in_ready", 32'(bus.in_ready), 32'(bus.out_ready || (exp_q.size() < LAT)));
        check("out_valid", 32'(bus.out_valid),
              32'((exp_q.size() > 0) && ((cyc - exp_q[0].acc) >= LAT)));
        if (held_vld) begin
            check("hold_S", 32'(bus.S), 32'(held_s));
            check("hold_Co", 32'(bus.Co), 32'(held_co));
            check("hold_GG_PG", 32'({bus.GG, bus.PG}), 32'({held_gg, held_pg}));
`ifdef CLA_OVF_EN
            check("hold_Ovf", 32'(bus.Ovf), 32'(held_ovf));
`endif
        end
        if (bus.out_valid && !bus.out_ready) begin
            held_vld = 1'b1;
            held_s   = bus.S;
            held_co  = bus.Co;
            held_gg  = bus.GG;
            held_pg  = bus.PG;
`ifdef CLA_OVF_EN
            held_ovf = bus.Ovf;
`endif
        end else begin
            held_vld = 1'b0;
        end
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("S", 32'(bus.S), 32'(e.s));
            check("Co", 32'(bus.Co), 32'(e.co));
            check("GG", 32'(bus.GG), 32'(e.gg));
            check("PG", 32'(bus.PG), 32'(e.pg));
`ifdef CLA_OVF_EN
            check("Ovf", 32'(bus.Ovf), 32'(e.ovf));
`endif
            if (lat_strict) check("latency", 32'(cyc - e.acc), 32'(LAT));
            n_out++;
        end
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) exp_q.push_back(model(bus.A, bus.B, bus.Ci, bus.Sub, cyc));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sub, input logic [W-1:0] es,
                            input logic eco, input logic egg, input logic epg, input logic eovf);
        bit acc;
        bus.A = a; bus.B = b; bus.Ci = ci; bus.Sub = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick(acc);
        bus.in_valid = 1'b0;
        tick(acc);
        check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_S"}, 32'(bus.S), 32'(es));
        check({tag, "_Co"}, 32'(bus.Co), 32'(eco));
        check({tag, "_GG_PG"}, 32'({bus.GG, bus.PG}), 32'({egg, epg}));
`ifdef CLA_OVF_EN
        check({tag, "_Ovf"}, 32'(bus.Ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("note: ovf expectation unknown for %s", tag);
`endif
        tick(acc);
    endtask

    initial begin
        bit           acc;
        int           sent;
        int           n0;
        bit           saw_block;
        logic [W-1:0] sa [8];
        logic [W-1:0] sb [8];

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.Ci = 1'b0; bus.Sub = 1'b0;
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_S", 32'(bus.S), 32'd0);
        check("rst_Co_GG_PG", 32'({bus.Co, bus.GG, bus.PG}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef CLA_OVF_EN
        check("rst_Ovf", 32'(bus.Ovf), 32'd0);
`endif
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        lat_strict = 1'b1;
        directed("inc_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("all_prop", 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Back-to-back throughput with exact latency
        for (int i = 0; i < 10; i++) begin
            bus.A = W'($urandom); bus.B = W'($urandom);
            bus.Ci = 1'($urandom); bus.Sub = 1'($urandom);
            bus.in_valid = 1'b1;
            tick(acc);
            check("tput_accept", 32'(acc), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick(acc); tick(acc);
        check("tput_drained", 32'(exp_q.size()), 32'd0);

        // 8-beat stream with a 3-cycle downstream stall
        lat_strict = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sa[i] = W'($urandom); sb[i] = W'($urandom);
        end
        sent = 0; n0 = n_out; saw_block = 1'b0;
        for (int i = 0; i < 40 && (sent < 8 || exp_q.size() > 0); i++) begin
            bus.out_ready = !(i >= 3 && i <= 5);
            bus.in_valid  = (sent < 8);
            if (sent < 8) begin
                bus.A = sa[sent]; bus.B = sb[sent];
                bus.Sub = sent[0]; bus.Ci = sent[1];
            end
            if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
            tick(acc);
            if (acc) sent++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        check("stream_count", 32'(n_out - n0), 32'd8);
        check("stream_backpressure", 32'(saw_block), 32'd1);

        // Random traffic on both sides
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.A = W'($urandom); bus.B = W'($urandom);
            bus.Ci = 1'($urandom); bus.Sub = 1'($urandom);
            tick(acc);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(acc);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with two beats in flight
        for (int i = 0; i < 2; i++) begin
            bus.A = 16'h1234 + W'(i); bus.B = 16'h4321; bus.Ci = 1'b1; bus.Sub = 1'b0;
            bus.in_valid = 1'b1;
            tick(acc);
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_S", 32'(bus.S), 32'd0);
        check("arst_Co_GG_PG", 32'({bus.Co, bus.GG, bus.PG}), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        exp_q.delete();
        held_vld = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        n0 = n_out;
        for (int i = 0; i < 6; i++) tick(acc);
        check("post_rst_no_results", 32'(n_out - n0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
